// File: rtl/bsk_pkg.sv
// bsk_pkg: shared constants, types and helpers for the BSK bus master.
//   Widths, chip-select codes, register address constants, the FSM state
//   enum and the latched host request payload.
package bsk_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned CS_W   = 4;
   localparam int unsigned CNT_W  = 4;

   localparam logic [CS_W-1:0] CS_16_01 = 4'b1011;
   localparam logic [CS_W-1:0] CS_32_17 = 4'b1001;
   localparam logic [CS_W-1:0] CS_IDLE  = 4'b1111;

   localparam logic [ADDR_W-1:0] REG_ADDR_0 = 2'b00;
   localparam logic [ADDR_W-1:0] REG_ADDR_1 = 2'b01;
   localparam logic [ADDR_W-1:0] REG_ADDR_2 = 2'b10;
   localparam logic [ADDR_W-1:0] REG_ADDR_3 = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      DONE
   } bskState_t;

   // Host request as captured in IDLE and held for the whole access.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic              unit;
      logic [DATA_W-1:0] wData;
   } bskReq_t;

   // Unit 0 addresses commands 16..01, unit 1 addresses commands 32..17.
   function automatic logic [CS_W-1:0] csForUnit(input logic unit);
      return unit ? CS_32_17 : CS_16_01;
   endfunction

endpackage

// File: rtl/bsk_bus_master_if.sv
// bsk_bus_master_if: host handshake and bus control signals of the BSK
// bus master.
//   Host side : iReq, iWe, iAddr, iUnit, iWData -> master; oBusy, oDone, oRData <- master
//   Bus side  : oA, oCS, oRd, oWr driven by the master
// The bidirectional data bus bD stays a plain inout port on the master.
interface bsk_bus_master_if;
   import bsk_pkg::*;

   logic              iReq;
   logic              iWe;
   logic [ADDR_W-1:0] iAddr;
   logic              iUnit;
   logic [DATA_W-1:0] iWData;

   logic              oBusy;
   logic              oDone;
   logic [DATA_W-1:0] oRData;
   logic [ADDR_W-1:0] oA;
   logic [CS_W-1:0]   oCS;
   logic              oRd;
   logic              oWr;

   modport master (
      input  iReq, iWe, iAddr, iUnit, iWData,
      output oBusy, oDone, oRData, oA, oCS, oRd, oWr
   );

   modport slave (
      output iReq, iWe, iAddr, iUnit, iWData,
      input  oBusy, oDone, oRData, oA, oCS, oRd, oWr
   );

endinterface

// File: rtl/bsk_phase_cnt.sv
// bsk_phase_cnt: loadable 4-bit down-counter timing one bus phase.
//   clk      : system clock
//   iRes     : synchronous active-high reset
//   iLoad    : load iLoadVal (phase length minus one) at phase entry
//   iLoadVal : reload value
//   oTc      : registered terminal-count flag, high while the count is zero
module bsk_phase_cnt
   import bsk_pkg::*;
(
   input  logic             clk,
   input  logic             iRes,
   input  logic             iLoad,
   input  logic [CNT_W-1:0] iLoadVal,
   output logic             oTc
);

   logic [CNT_W-1:0] cnt;

   // Counts down to zero and parks there; the flag tracks the next count.
   always_ff @(posedge clk) begin
      if (iRes) begin
         cnt <= '0;
         oTc <= 1'b1;
      end else if (iLoad) begin
         cnt <= iLoadVal;
         oTc <= (iLoadVal == '0);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
         oTc <= (cnt == CNT_W'(1));
      end
   end

endmodule

// File: rtl/bsk_bus_master.sv
// bsk_bus_master: host-to-BSK parallel bus master with programmable
// setup/strobe/hold timing.
//   clk  : system clock, rising edge
//   iRes : synchronous active-high reset
//   bus  : host request/response and bus address/CS/strobes (master modport)
//   bD   : bidirectional data bus, driven only during write accesses
module bsk_bus_master
   import bsk_pkg::*;
#(
   parameter int unsigned T_SETUP  = 2,
   parameter int unsigned T_STROBE = 4,
   parameter int unsigned T_HOLD   = 2
) (
   input  logic              clk,
   input  logic              iRes,
   bsk_bus_master_if.master  bus,
   inout  wire  [DATA_W-1:0] bD
);

   bskState_t         state;
   bskState_t         stateNext;
   bskReq_t           reqQ;
   bskReq_t           reqNext;
   logic              cntLoad;
   logic [CNT_W-1:0]  cntLoadVal;
   logic              cntTc;
   logic              drvEn;
   logic              active;
   logic              busyNext;
   logic              doneNext;
   logic [DATA_W-1:0] rDataNext;
   logic [ADDR_W-1:0] aNext;
   logic [CS_W-1:0]   csNext;
   logic              rdNext;
   logic              wrNext;
   logic              drvEnNext;

   bsk_phase_cnt u_phaseCnt (
      .clk      (clk),
      .iRes     (iRes),
      .iLoad    (cntLoad),
      .iLoadVal (cntLoadVal),
      .oTc      (cntTc)
   );

   // Next state, phase reloads and next values of every registered output.
   always_comb begin
      stateNext  = state;
      reqNext    = reqQ;
      cntLoad    = 1'b0;
      cntLoadVal = '0;
      rDataNext  = bus.oRData;

      case (state)
         IDLE: begin
            if (bus.iReq) begin
               stateNext  = SETUP;
               reqNext    = '{we: bus.iWe, addr: bus.iAddr, unit: bus.iUnit, wData: bus.iWData};
               cntLoad    = 1'b1;
               cntLoadVal = CNT_W'(T_SETUP - 1);
            end
         end
         SETUP: begin
            if (cntTc) begin
               stateNext  = STROBE;
               cntLoad    = 1'b1;
               cntLoadVal = CNT_W'(T_STROBE - 1);
            end
         end
         STROBE: begin
            if (cntTc) begin
               stateNext  = HOLD;
               cntLoad    = 1'b1;
               cntLoadVal = CNT_W'(T_HOLD - 1);
               // Read data is taken at the end of the last strobe cycle.
               if (!reqQ.we) begin
                  rDataNext = bD;
               end
            end
         end
         HOLD: begin
            if (cntTc) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      active    = (stateNext == SETUP) || (stateNext == STROBE) || (stateNext == HOLD);
      busyNext  = (stateNext != IDLE);
      doneNext  = (stateNext == DONE);
      csNext    = active ? csForUnit(reqNext.unit) : CS_IDLE;
      aNext     = active ? reqNext.addr : '0;
      rdNext    = !((stateNext == STROBE) && !reqNext.we);
      wrNext    = !((stateNext == STROBE) && reqNext.we);
      drvEnNext = active && reqNext.we;
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (iRes) begin
         state      <= IDLE;
         reqQ       <= '0;
         drvEn      <= 1'b0;
         bus.oBusy  <= 1'b0;
         bus.oDone  <= 1'b0;
         bus.oRData <= '0;
         bus.oA     <= '0;
         bus.oCS    <= CS_IDLE;
         bus.oRd    <= 1'b1;
         bus.oWr    <= 1'b1;
      end else begin
         state      <= stateNext;
         reqQ       <= reqNext;
         drvEn      <= drvEnNext;
         bus.oBusy  <= busyNext;
         bus.oDone  <= doneNext;
         bus.oRData <= rDataNext;
         bus.oA     <= aNext;
         bus.oCS    <= csNext;
         bus.oRd    <= rdNext;
         bus.oWr    <= wrNext;
      end
   end

   assign bD = drvEn ? reqQ.wData : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bsk_bus_master.sv
// tb_bsk_bus_master: two bus masters (default timing and 1/1/1 timing) run
// side by side on the same host stimulus; each is compared every cycle
// against a transaction-level model that tracks cycles since acceptance.
module tb_bsk_bus_master;
   import bsk_pkg::*;

   logic        clk = 1'b0;
   logic        iRes;
   logic        req;
   logic        we;
   logic        unit;
   logic [1:0]  addr;
   logic [15:0] wData;
   logic [15:0] bdVal;
   logic [1:0]  tbDrv;
   wire  [15:0] bdA;
   wire  [15:0] bdB;

   int nChecks = 0;
   int nFails  = 0;

   // Model state per DUT: k = cycles since acceptance (0 = idle).
   int          k      [2];
   int          pS     [2];
   int          pT     [2];
   int          pH     [2];
   bskReq_t     mReq   [2];
   logic [15:0] mRData [2];

   always #5 clk = ~clk;

   bsk_bus_master_if busA ();
   bsk_bus_master_if busB ();

   assign busA.iReq   = req;
   assign busA.iWe    = we;
   assign busA.iAddr  = addr;
   assign busA.iUnit  = unit;
   assign busA.iWData = wData;
   assign busB.iReq   = req;
   assign busB.iWe    = we;
   assign busB.iAddr  = addr;
   assign busB.iUnit  = unit;
   assign busB.iWData = wData;

   // Peripheral side of the data bus: drives whenever the master should not.
   assign bdA = tbDrv[0] ? bdVal : 16'hzzzz;
   assign bdB = tbDrv[1] ? bdVal : 16'hzzzz;

   bsk_bus_master #(.T_SETUP(2), .T_STROBE(4), .T_HOLD(2)) dutA (
      .clk  (clk),
      .iRes (iRes),
      .bus  (busA),
      .bD   (bdA)
   );

   bsk_bus_master #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) dutB (
      .clk  (clk),
      .iRes (iRes),
      .bus  (busB),
      .bD   (bdB)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic writing(input int d);
      return (k[d] >= 1) && (k[d] <= pS[d] + pT[d] + pH[d]) && mReq[d].we;
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic advance(input int d);
      int tot;
      tot = pS[d] + pT[d] + pH[d];
      if (iRes) begin
         k[d]      = 0;
         mRData[d] = 16'h0000;
      end else if (k[d] == 0) begin
         if (req) begin
            k[d]    = 1;
            mReq[d] = '{we: we, addr: addr, unit: unit, wData: wData};
         end
      end else begin
         if (!mReq[d].we && (k[d] == pS[d] + pT[d])) begin
            mRData[d] = bdVal;
         end
         k[d] = (k[d] == tot + 1) ? 0 : k[d] + 1;
      end
   endtask

   task automatic compare(input int d, input logic busy, input logic done,
                          input logic [15:0] rdat, input logic [1:0] a,
                          input logic [3:0] cs, input logic rd, input logic wr,
                          input logic [15:0] bd);
      string       p;
      int          tot;
      logic        act;
      logic        stb;
      logic [3:0]  csExp;
      p     = (d == 0) ? "A." : "B.";
      tot   = pS[d] + pT[d] + pH[d];
      act   = (k[d] >= 1) && (k[d] <= tot);
      stb   = (k[d] > pS[d]) && (k[d] <= pS[d] + pT[d]);
      csExp = !act ? 4'b1111 : (mReq[d].unit ? 4'b1001 : 4'b1011);
      chk({p, "busy"},  32'(busy), 32'(k[d] != 0));
      chk({p, "done"},  32'(done), 32'(k[d] == tot + 1));
      chk({p, "rData"}, 32'(rdat), 32'(mRData[d]));
      chk({p, "addr"},  32'(a),    32'(act ? mReq[d].addr : 2'b00));
      chk({p, "cs"},    32'(cs),   32'(csExp));
      chk({p, "rd"},    32'(rd),   32'(!(stb && !mReq[d].we)));
      chk({p, "wr"},    32'(wr),   32'(!(stb && mReq[d].we)));
      chk({p, "noOverlap"}, 32'(rd | wr), 32'(1));
      if (act && mReq[d].we) begin
         chk({p, "bD"}, 32'(bd), 32'(mReq[d].wData));
      end
   endtask

   // One clock: model update at the edge, check #1 later, return at negedge.
   task automatic cycle();
      @(posedge clk);
      for (int d = 0; d < 2; d++) advance(d);
      tbDrv[0] = !writing(0);
      tbDrv[1] = !writing(1);
      #1;
      compare(0, busA.oBusy, busA.oDone, busA.oRData, busA.oA, busA.oCS, busA.oRd, busA.oWr, bdA);
      compare(1, busB.oBusy, busB.oDone, busB.oRData, busB.oA, busB.oCS, busB.oRd, busB.oWr, bdB);
      @(negedge clk);
   endtask

   task automatic request(input logic w, input logic [1:0] ad, input logic u, input logic [15:0] dat);
      we    = w;
      addr  = ad;
      unit  = u;
      wData = dat;
      req   = 1'b1;
      cycle();
      req   = 1'b0;
   endtask

   initial begin
      int cntA;
      int cntB;
      int aux;
      logic [1:0] addrTab [4];

      addrTab = '{REG_ADDR_0, REG_ADDR_1, REG_ADDR_2, REG_ADDR_3};
      pS = '{2, 1};
      pT = '{4, 1};
      pH = '{2, 1};
      k  = '{0, 0};
      mRData = '{16'h0000, 16'h0000};
      mReq   = '{'0, '0};
      iRes  = 1'b1;
      req   = 1'b0;
      we    = 1'b0;
      unit  = 1'b0;
      addr  = 2'b00;
      wData = 16'h0000;
      bdVal = 16'h0000;
      tbDrv = 2'b11;

      // Reset values.
      repeat (3) cycle();
      chk("rst.cs",    32'(busA.oCS),    32'(4'b1111));
      chk("rst.rData", 32'(busA.oRData), 32'(16'h0000));
      chk("rst.rdwr",  32'({busA.oRd, busA.oWr}), 32'(2'b11));
      iRes = 1'b0;
      cycle();

      // Write unit 0, addr 2, data 1111: latency, CS window and strobe width.
      bdVal = 16'h5A5A;
      request(1'b1, REG_ADDR_2, 1'b0, 16'h1111);
      cntA = 0; cntB = 0; aux = 0;
      for (int i = 1; i <= 12; i++) begin
         if (busA.oDone && cntA == 0) cntA = i;
         if (busB.oDone && cntB == 0) cntB = i;
         if (!busA.oWr) aux++;
         cycle();
      end
      chk("A.wrLatency", 32'(cntA), 32'(9));
      chk("B.wrLatency", 32'(cntB), 32'(4));
      chk("A.wrLowCycles", 32'(aux), 32'(4));

      // Read unit 0, addr 0 with the peripheral presenting 1331.
      bdVal = 16'h1331;
      request(1'b0, REG_ADDR_0, 1'b0, 16'hFFFF);
      aux = 0;
      for (int i = 1; i <= 12; i++) begin
         if (!busA.oRd) aux++;
         cycle();
      end
      chk("A.rdLowCycles", 32'(aux), 32'(4));
      chk("A.rdData0", 32'(busA.oRData), 32'(16'h1331));
      chk("B.rdData0", 32'(busB.oRData), 32'(16'h1331));

      // Read unit 1, addr 3.
      bdVal = 16'hA462;
      request(1'b0, REG_ADDR_3, 1'b1, 16'h0000);
      aux = 0;
      for (int i = 1; i <= 12; i++) begin
         if (busA.oBusy && i <= 8 && busA.oCS == 4'b1001) aux++;
         cycle();
      end
      chk("A.cs1Cycles", 32'(aux), 32'(8));
      chk("A.rdData1", 32'(busA.oRData), 32'(16'hA462));

      // Requests during SETUP and HOLD are ignored; back-to-back after DONE.
      bdVal = 16'h0F0F;
      request(1'b1, REG_ADDR_1, 1'b1, 16'hC0DE);
      cntA = 0; aux = 0;
      for (int i = 1; i <= 12; i++) begin
         if (busA.oDone) cntA++;
         if (i == 11) aux = int'(busA.oBusy);
         req = (i == 1) || (i == 7) || (i == 10);
         we  = 1'b0;
         cycle();
      end
      req = 1'b0;
      chk("A.doneCount", 32'(cntA), 32'(1));
      chk("A.b2bBusy", 32'(aux), 32'(1));
      repeat (12) cycle();

      // Reset in the second strobe cycle of a write aborts it.
      request(1'b1, REG_ADDR_2, 1'b0, 16'hBEEF);
      cntA = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 5) begin
            chk("A.abortWr",    32'(busA.oWr),    32'(1));
            chk("A.abortCS",    32'(busA.oCS),    32'(4'b1111));
            chk("A.abortRData", 32'(busA.oRData), 32'(16'h0000));
         end
         if (i >= 5 && busA.oDone) cntA++;
         iRes = (i == 4);
         cycle();
      end
      iRes = 1'b0;
      chk("A.abortDone", 32'(cntA), 32'(0));

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         req   = 1'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         unit  = 1'($urandom_range(0, 1));
         addr  = addrTab[$urandom_range(0, 3)];
         wData = 16'($urandom);
         bdVal = 16'($urandom);
         iRes  = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
